// File: rtl/s_mem_sequencer.sv
// s_mem_sequencer: steps init -> shuffle -> decrypt phase blocks and muxes their S-memory ports onto one port.
// Latency: start -> INIT (with launch pulse) next edge; sampled finish outside the pulse cycle -> next phase next edge.
// Backpressure: none; each phase waits on its finish level. Macro S_MEM_SEQUENCER_TIMEOUT_EN adds a per-phase abort to ERR.
module s_mem_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       init_start,
  output logic       shuffle_start,
  output logic       decrypt_start,
  input  logic       init_finish,
  input  logic       shuffle_finish,
  input  logic       decrypt_finish,
  input  logic [7:0] init_addr,
  input  logic [7:0] shuffle_addr,
  input  logic [7:0] decrypt_addr,
  input  logic [7:0] init_data,
  input  logic [7:0] shuffle_data,
  input  logic [7:0] decrypt_data,
  input  logic       init_wren,
  input  logic       shuffle_wren,
  input  logic       decrypt_wren,
  output logic [7:0] mem_address,
  output logic [7:0] mem_data,
  output logic       mem_wren,
  output logic [2:0] phase,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHUFFLE = 3'd2,
    S_DECRYPT = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        init_start_q, init_start_d;
  logic        shuffle_start_q, shuffle_start_d;
  logic        decrypt_start_q, decrypt_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pulse_cycle;
  logic        entering;
  logic        in_phase;
  logic        timeout_hit;

`ifdef S_MEM_SEQUENCER_TIMEOUT_EN
  // Abort a phase once its cycle counter reaches the last allowed cycle
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  assign timeout_hit = (cnt_q == CNT_LAST);
`else
  // No abort: phases wait for their finish indefinitely
  logic [15:0] unused_cnt_last;
  assign unused_cnt_last = 16'(TIMEOUT_CYCLES - 1);
  assign timeout_hit     = 1'b0;
`endif

  // Next state, launch pulses, phase counter and status flags
  always_comb begin
    state_d     = state_q;
    // A finish seen during the launch cycle is a stale level from the previous run
    pulse_cycle = init_start_q | shuffle_start_q | decrypt_start_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_INIT;
      S_INIT:    if (init_finish && !pulse_cycle) state_d = S_SHUFFLE;
                 else if (timeout_hit) state_d = S_ERR;
      S_SHUFFLE: if (shuffle_finish && !pulse_cycle) state_d = S_DECRYPT;
                 else if (timeout_hit) state_d = S_ERR;
      S_DECRYPT: if (decrypt_finish && !pulse_cycle) state_d = S_DONE;
                 else if (timeout_hit) state_d = S_ERR;
      S_DONE:    if (start) state_d = S_INIT;
      S_ERR:     if (start) state_d = S_INIT;
      default:   state_d = S_IDLE;
    endcase

    entering = (state_d != state_q);
    in_phase = (state_q == S_INIT) || (state_q == S_SHUFFLE) || (state_q == S_DECRYPT);

    init_start_d    = entering && (state_d == S_INIT);
    shuffle_start_d = entering && (state_d == S_SHUFFLE);
    decrypt_start_d = entering && (state_d == S_DECRYPT);

    if (entering) begin
      cnt_d = 16'd0;
    end else if (in_phase && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end

    busy_d  = (state_d == S_INIT) || (state_d == S_SHUFFLE) || (state_d == S_DECRYPT);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERR);
  end

  // State and registered outputs, cleared asynchronously on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      init_start_q    <= 1'b0;
      shuffle_start_q <= 1'b0;
      decrypt_start_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      cnt_q           <= 16'd0;
    end else begin
      state_q         <= state_d;
      init_start_q    <= init_start_d;
      shuffle_start_q <= shuffle_start_d;
      decrypt_start_q <= decrypt_start_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      cnt_q           <= cnt_d;
    end
  end

  // Memory port follows the phase owning the current state; idle elsewhere so stray writes never pass
  always_comb begin
    mem_address = 8'h00;
    mem_data    = 8'h00;
    mem_wren    = 1'b0;
    case (state_q)
      S_INIT: begin
        mem_address = init_addr;
        mem_data    = init_data;
        mem_wren    = init_wren;
      end
      S_SHUFFLE: begin
        mem_address = shuffle_addr;
        mem_data    = shuffle_data;
        mem_wren    = shuffle_wren;
      end
      S_DECRYPT: begin
        mem_address = decrypt_addr;
        mem_data    = decrypt_data;
        mem_wren    = decrypt_wren;
      end
      default: begin
        mem_address = 8'h00;
        mem_data    = 8'h00;
        mem_wren    = 1'b0;
      end
    endcase
  end

  assign init_start    = init_start_q;
  assign shuffle_start = shuffle_start_q;
  assign decrypt_start = decrypt_start_q;
  assign phase         = state_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_s_mem_sequencer.sv
`timescale 1ns/1ps
// Bench for s_mem_sequencer: directed runs, expected events queued by stimulus, checked by a negedge monitor.
module tb_s_mem_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       init_start, shuffle_start, decrypt_start;
  logic       init_finish = 1'b0, shuffle_finish = 1'b0, decrypt_finish = 1'b0;
  logic [7:0] init_addr = 8'h00, shuffle_addr = 8'h00, decrypt_addr = 8'h00;
  logic [7:0] init_data = 8'h00, shuffle_data = 8'h00, decrypt_data = 8'h00;
  logic       init_wren = 1'b0, shuffle_wren = 1'b0, decrypt_wren = 1'b0;
  logic [7:0] mem_address, mem_data;
  logic       mem_wren;
  logic [2:0] phase;
  logic       busy, done, error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0, c1, c2, c3;

  typedef enum int {EV_INIT, EV_SHUF, EV_DEC, EV_WR, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         cyc;
    logic [2:0] phase;
    logic       busy;
    logic       err;
    logic       chk_mem;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  s_mem_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .init_start(init_start), .shuffle_start(shuffle_start), .decrypt_start(decrypt_start),
    .init_finish(init_finish), .shuffle_finish(shuffle_finish), .decrypt_finish(decrypt_finish),
    .init_addr(init_addr), .shuffle_addr(shuffle_addr), .decrypt_addr(decrypt_addr),
    .init_data(init_data), .shuffle_data(shuffle_data), .decrypt_data(decrypt_data),
    .init_wren(init_wren), .shuffle_wren(shuffle_wren), .decrypt_wren(decrypt_wren),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .phase(phase), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input int c, input logic [2:0] ph, input logic b,
                      input logic m, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.cyc = c; e.phase = ph; e.busy = b; e.err = (k == EV_ERR);
    e.chk_mem = m; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_pulse(input ev_kind_t k, input int c);
    logic [2:0] ph;
    ph = (k == EV_INIT) ? 3'd1 : (k == EV_SHUF) ? 3'd2 : 3'd3;
    push(k, c, ph, 1'b1, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic push_wr(input int c, input logic [2:0] ph, input logic [7:0] a, input logic [7:0] d);
    push(EV_WR, c, ph, 1'b1, 1'b1, a, d);
  endtask

  task automatic observe(input ev_kind_t k, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got event at cycle %0d, expected none", nm, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, "_kind"}, int'(k), int'(e.kind));
    chk({nm, "_cycle"}, cyc, e.cyc);
    chk({nm, "_phase"}, int'(phase), int'(e.phase));
    chk({nm, "_busy"}, int'(busy), int'(e.busy));
    chk({nm, "_error"}, int'(error), int'(e.err));
    if (e.chk_mem) begin
      chk({nm, "_addr"}, int'(mem_address), int'(e.addr));
      chk({nm, "_data"}, int'(mem_data), int'(e.data));
    end
  endtask

  // Monitor: every DUT output event pops the next expectation
  logic done_prev = 1'b0, error_prev = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (init_start)          observe(EV_INIT, "init_start");
      if (shuffle_start)       observe(EV_SHUF, "shuffle_start");
      if (decrypt_start)       observe(EV_DEC, "decrypt_start");
      if (mem_wren)            observe(EV_WR, "mem_write");
      if (done && !done_prev)  observe(EV_DONE, "done");
      if (error && !error_prev) observe(EV_ERR, "error");
    end
    done_prev  <= done;
    error_prev <= error;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected end before 50000ns");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #2;
    chk("rst_phase", int'(phase), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_pulses", int'({init_start, shuffle_start, decrypt_start}), 0);
    chk("rst_mem", int'({mem_address, mem_data, mem_wren}), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("idle_hold_phase", int'(phase), 0);

    // Run 1: nominal timing, grant and non-granted write/finish filtering
    c0 = cyc;
    push_pulse(EV_INIT, c0 + 1);
    push_wr(c0 + 2, 3'd1, 8'h01, 8'h02);
    push_pulse(EV_SHUF, c0 + 5);
    push_wr(c0 + 6, 3'd2, 8'h22, 8'h5A);
    push_pulse(EV_DEC, c0 + 9);
    push_wr(c0 + 10, 3'd3, 8'h80, 8'hC3);
    push(EV_DONE, c0 + 13, 3'd4, 1'b0, 1'b0, 8'h00, 8'h00);
    start = 1'b1; tick();
    start = 1'b0; tick();
    init_wren = 1'b1; init_addr = 8'h01; init_data = 8'h02;
    shuffle_finish = 1'b1; decrypt_finish = 1'b1; tick();
    init_wren = 1'b0; shuffle_finish = 1'b0; decrypt_finish = 1'b0; tick();
    init_finish = 1'b1; shuffle_wren = 1'b1; shuffle_addr = 8'h44; shuffle_data = 8'h55; tick();
    init_finish = 1'b0; shuffle_wren = 1'b0; init_wren = 1'b1; init_addr = 8'h10; init_data = 8'h33; tick();
    shuffle_wren = 1'b1; shuffle_addr = 8'h22; shuffle_data = 8'h5A;
    decrypt_wren = 1'b1; decrypt_addr = 8'h77; decrypt_data = 8'h88; tick();
    init_wren = 1'b0; shuffle_wren = 1'b0; decrypt_wren = 1'b0; tick();
    shuffle_finish = 1'b1; tick();
    shuffle_finish = 1'b0; tick();
    decrypt_wren = 1'b1; decrypt_addr = 8'h80; decrypt_data = 8'hC3; tick();
    decrypt_wren = 1'b0; tick();
    decrypt_finish = 1'b1; tick();
    decrypt_finish = 1'b0; tick();
    chk("done_hold_done", int'(done), 1);
    chk("done_hold_phase", int'(phase), 4);

    // Run 2: stale init_finish held across restart from DONE
    init_finish = 1'b1; tick();
    c1 = cyc;
    push_pulse(EV_INIT, c1 + 1);
    push_pulse(EV_SHUF, c1 + 3);
    push_pulse(EV_DEC, c1 + 7);
    push(EV_DONE, c1 + 9, 3'd4, 1'b0, 1'b0, 8'h00, 8'h00);
    start = 1'b1; tick();
    start = 1'b0; tick();
    chk("stale_finish_init_held", int'(phase), 1);
    tick();
    shuffle_finish = 1'b1; tick();
    chk("no_double_skip", int'(phase), 2);
    shuffle_finish = 1'b0; init_finish = 1'b0; tick();
    tick();
    shuffle_finish = 1'b1; tick();
    shuffle_finish = 1'b0; decrypt_finish = 1'b1; tick();
    tick();
    decrypt_finish = 1'b0; tick();

    // Run 3: start held high -> one sequence, then exactly one restart
    c2 = cyc;
    push_pulse(EV_INIT, c2 + 1);
    push_pulse(EV_SHUF, c2 + 3);
    push_pulse(EV_DEC, c2 + 5);
    push(EV_DONE, c2 + 7, 3'd4, 1'b0, 1'b0, 8'h00, 8'h00);
    push_pulse(EV_INIT, c2 + 8);
    push_pulse(EV_SHUF, c2 + 10);
    push_pulse(EV_DEC, c2 + 12);
    push_wr(c2 + 13, 3'd3, 8'h99, 8'h11);
    start = 1'b1; tick();
    tick();
    init_finish = 1'b1; tick();
    init_finish = 1'b0; tick();
    shuffle_finish = 1'b1; tick();
    shuffle_finish = 1'b0; tick();
    decrypt_finish = 1'b1; tick();
    decrypt_finish = 1'b0; tick();
    start = 1'b0; tick();
    init_finish = 1'b1; tick();
    init_finish = 1'b0; tick();
    shuffle_finish = 1'b1; tick();
    shuffle_finish = 1'b0; tick();
    decrypt_wren = 1'b1; decrypt_addr = 8'h99; decrypt_data = 8'h11;
    #1;
    chk("pre_reset_wren", int'(mem_wren), 1);

    // Asynchronous reset mid-write in DECRYPT
    #5 reset_n = 1'b0;
    #1;
    chk("async_rst_wren", int'(mem_wren), 0);
    chk("async_rst_phase", int'(phase), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_pulse", int'(decrypt_start), 0);
    chk("async_rst_addr", int'(mem_address), 0);
    tick(); tick();
    decrypt_wren = 1'b0; reset_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_idle", int'(phase), 0);
    chk("post_rst_busy", int'(busy), 0);

    // Run 4: stalled SHUFFLE phase
    c3 = cyc;
`ifdef S_MEM_SEQUENCER_TIMEOUT_EN
    push_pulse(EV_INIT, c3 + 1);
    push_pulse(EV_SHUF, c3 + 3);
    push(EV_ERR, c3 + 19, 3'd5, 1'b0, 1'b1, 8'h00, 8'h00);
    push_pulse(EV_INIT, c3 + 21);
    start = 1'b1; tick();
    start = 1'b0; tick();
    init_finish = 1'b1; tick();
    init_finish = 1'b0;
    repeat (16) tick();
    shuffle_wren = 1'b1; shuffle_addr = 8'h05; tick();
    chk("err_phase", int'(phase), 5);
    chk("err_flag", int'(error), 1);
    chk("err_mem_idle", int'(mem_wren), 0);
    shuffle_wren = 1'b0; start = 1'b1; tick();
    start = 1'b0; tick();
`else
    push_pulse(EV_INIT, c3 + 1);
    push_pulse(EV_SHUF, c3 + 3);
    push_pulse(EV_DEC, c3 + 44);
    start = 1'b1; tick();
    start = 1'b0; tick();
    init_finish = 1'b1; tick();
    init_finish = 1'b0;
    repeat (40) tick();
    chk("no_timeout_phase", int'(phase), 2);
    chk("no_timeout_error", int'(error), 0);
    shuffle_finish = 1'b1; tick();
    shuffle_finish = 1'b0; tick();
`endif

    // Drain outstanding expectations with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s_mem_sequencer.md
S_MEM_SEQUENCER -- requirements
Module: s_mem_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, is the maximum cycles one phase may run before abort (used only when the Configuration macro is defined).
REQ-002 Ports SHALL be: clk  input  1  sole clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to run the full init -> shuffle -> decrypt sequence.
REQ-005 init_start, shuffle_start, decrypt_start  output  1 each  one-cycle launch pulse to each phase block.
REQ-006 init_finish, shuffle_finish, decrypt_finish  input  1 each  completion level from each phase block.
REQ-007 init_addr/shuffle_addr/decrypt_addr  input  8 each; init_data/shuffle_data/decrypt_data  input  8 each; init_wren/shuffle_wren/decrypt_wren  input  1 each  per-requester S-memory port.
REQ-008 mem_address  output  8; mem_data  output  8; mem_wren  output  1  muxed single-port S-memory port.
REQ-009 phase  output  3  current state encoding; busy  output  1; done  output  1; error  output  1.

Function
REQ-010 FSM states SHALL be IDLE=0, INIT=1, SHUFFLE=2, DECRYPT=3, DONE=4, ERR=5; phase equals the state code.
REQ-011 IDLE: start=1 -> INIT next edge; start=0 -> stay.
REQ-012 On each entry into INIT/SHUFFLE/DECRYPT, the matching *_start is high for exactly the first cycle in that state, all other cycles low.
REQ-013 In a phase state, finish of the granted requester sampled high on any cycle after the start-pulse cycle -> advance INIT->SHUFFLE->DECRYPT->DONE next edge.
REQ-014 Finish sampled during the start-pulse cycle SHALL be ignored (stale level from previous run).
REQ-015 Finish inputs of non-granted requesters SHALL be ignored in every state.
REQ-016 Grant: mem_address/mem_data/mem_wren combinationally follow the requester owning the current state; in IDLE, DONE, ERR outputs are 0x00, 0x00, 0.
REQ-017 Non-granted *_wren SHALL never reach mem_wren, including on the transition cycle.
REQ-018 busy=1 in INIT/SHUFFLE/DECRYPT, else 0; done=1 only in DONE.
REQ-019 start while busy is ignored; start in DONE returns to INIT next edge (full rerun), done drops same edge.
REQ-020 Phase cycle counter (16-bit, saturating) resets to 0 on each phase entry and increments each phase cycle.

Reset
REQ-021 reset_n low SHALL asynchronously force IDLE, all *_start=0, counter=0, done=0, busy=0, error=0.
REQ-022 Because grant decodes from state, mem_wren SHALL be 0 immediately on reset assertion, mid-write included.
REQ-023 After reset_n rises, no transition until the first rising clk edge with start=1.

Configuration
REQ-024 Macro S_MEM_SEQUENCER_TIMEOUT_EN defined: counter reaching TIMEOUT_CYCLES-1 in a phase without finish -> ERR next edge; error=1, memory port idle; only reset or start (-> INIT, error cleared) leaves ERR.
REQ-025 Macro undefined: no timeout, ERR unreachable, error tied 0, phases wait indefinitely.

Verification
REQ-026 Reset, start pulse 1 cycle, each finish 3 cycles after its start pulse -> start pulses at cycles 1, 5, 9, phase 1->2->3->4, done=1 at cycle 13.
REQ-027 During SHUFFLE drive init_wren=1 addr 0x10, shuffle_wren=1 addr 0x22 data 0x5A -> mem_address=0x22, mem_data=0x5A, mem_wren=1.
REQ-028 Hold init_finish=1 from previous run, start from DONE -> INIT persists past pulse cycle, then advances only on next sampled finish; no double skip.
REQ-029 Assert reset_n low mid-DECRYPT with decrypt_wren=1 -> mem_wren=0 same cycle without clock, phase=0, busy=0.
REQ-030 Macro defined, TIMEOUT_CYCLES=16, shuffle_finish never set -> ERR 16 cycles after SHUFFLE entry, error=1; start -> INIT, error=0.
REQ-031 start held high throughout run -> single sequence; DONE reached then immediately restarts INIT with exactly one init_start pulse.
